// File: rtl/line_feeder.sv
// Three-row line feeder: loads a 3-row band from source memory, streams it column by
// column to a 3x3 convolver, then refills the oldest rows one stride at a time.
module line_feeder #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           stride,
    input  logic [ADDR_W-1:0]    src_base,
    output logic                 src_rd_en,
    output logic [ADDR_W-1:0]    src_addr,
    input  logic [BIT_DEPTH-1:0] src_data,
    input  logic                 shift_buffer,
    output logic [BIT_DEPTH-1:0] out_l1,
    output logic [BIT_DEPTH-1:0] out_l2,
    output logic [BIT_DEPTH-1:0] out_l3,
    output logic                 col_valid,
    output logic                 band_done,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = $clog2(IMG_H + 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_REFILL,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic              stride2_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [CW-1:0]     col_reg;
    logic [RW-1:0]     row_top_reg;
    logic [1:0]        top_reg;
    logic [CW-1:0]     rd_col_reg;
    logic [RW-1:0]     rd_row_reg;
    logic [1:0]        rd_bank_reg;
    logic [1:0]        rd_left_reg;
    logic              wr_en_reg;
    logic              wr_last_reg;
    logic [1:0]        wr_bank_reg;
    logic [CW-1:0]     wr_col_reg;
    logic              band_done_reg;

    logic [1:0]        stride_val;
    logic              start_accept;
    logic              in_load;
    logic              rd_row_end;
    logic              band_end;
    logic              last_band;
    logic [ADDR_W-1:0] addr_calc;

    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    assign stride_val   = stride2_reg ? 2'd2 : 2'd1;
    assign start_accept = (state_reg == S_IDLE) && start;
    assign in_load      = (state_reg == S_FILL) || (state_reg == S_REFILL);
    assign src_rd_en    = in_load && (rd_left_reg != 2'd0);
    assign rd_row_end   = (rd_col_reg == CW'(IMG_W - 1));
    assign col_valid    = (state_reg == S_STREAM);
    assign band_end     = col_valid && shift_buffer && (col_reg == CW'(IMG_W - 1));
    assign last_band    = (int'(row_top_reg) + int'(stride_val) + 2) > (IMG_H - 1);
    // Address wraps modulo 2^ADDR_W by truncation of the sum.
    assign addr_calc    = base_reg + ADDR_W'(int'(rd_row_reg) * IMG_W) + ADDR_W'(rd_col_reg);
    assign src_addr     = src_rd_en ? addr_calc : '0;
    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_DONE);
    assign band_done    = band_done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_FILL;
            S_FILL:   if (wr_last_reg) state_next = S_STREAM;
            S_STREAM: if (band_end) state_next = last_band ? S_DONE : S_REFILL;
            S_REFILL: if (wr_last_reg) state_next = S_STREAM;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stride2_reg   <= 1'b0;
            base_reg      <= '0;
            col_reg       <= '0;
            row_top_reg   <= '0;
            top_reg       <= '0;
            rd_col_reg    <= '0;
            rd_row_reg    <= '0;
            rd_bank_reg   <= '0;
            rd_left_reg   <= '0;
            wr_en_reg     <= 1'b0;
            wr_last_reg   <= 1'b0;
            wr_bank_reg   <= '0;
            wr_col_reg    <= '0;
            band_done_reg <= 1'b0;
        end else begin
            band_done_reg <= band_end;
            wr_en_reg     <= src_rd_en;
            wr_last_reg   <= src_rd_en && rd_row_end && (rd_left_reg == 2'd1);
            wr_bank_reg   <= rd_bank_reg;
            wr_col_reg    <= rd_col_reg;

            if (start_accept) begin
                stride2_reg <= (stride == 2'b10);
                base_reg    <= src_base;
                col_reg     <= '0;
                row_top_reg <= '0;
                top_reg     <= '0;
                rd_col_reg  <= '0;
                rd_row_reg  <= '0;
                rd_bank_reg <= '0;
                rd_left_reg <= 2'd3;
            end

            if (src_rd_en) begin
                if (rd_row_end) begin
                    rd_col_reg  <= '0;
                    rd_row_reg  <= rd_row_reg + RW'(1);
                    rd_bank_reg <= add_mod3(rd_bank_reg, 2'd1);
                    rd_left_reg <= rd_left_reg - 2'd1;
                end else begin
                    rd_col_reg <= rd_col_reg + CW'(1);
                end
            end

            if (col_valid && shift_buffer) begin
                col_reg <= band_end ? '0 : col_reg + CW'(1);
            end

            // Bank top always holds row row_top (mod 3), so the next new row lands there.
            if (band_end && !last_band) begin
                rd_col_reg  <= '0;
                rd_row_reg  <= row_top_reg + RW'(3);
                rd_bank_reg <= top_reg;
                rd_left_reg <= stride_val;
            end

            if ((state_reg == S_REFILL) && wr_last_reg) begin
                top_reg     <= add_mod3(top_reg, stride_val);
                row_top_reg <= row_top_reg + RW'(stride_val);
            end
        end
    end

    logic [BIT_DEPTH-1:0] col_pix  [3];
    logic [BIT_DEPTH-1:0] line_pix [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_bank
        logic [BIT_DEPTH-1:0] mem [IMG_W];

        always_ff @(posedge clk) begin
            if (wr_en_reg && (wr_bank_reg == 2'(gi))) begin
                mem[wr_col_reg] <= src_data;
            end
        end

        assign col_pix[gi] = mem[col_reg];
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_line
        logic [1:0] sel;
        assign sel          = add_mod3(top_reg, 2'(gi));
        assign line_pix[gi] = col_valid ? col_pix[sel] : '0;
    end

    assign out_l1 = line_pix[0];
    assign out_l2 = line_pix[1];
    assign out_l3 = line_pix[2];

endmodule

// File: tb/tb_line_feeder.sv
// Directed bench for line_feeder: memory returns mem[a]=a one cycle after each read.
module tb_line_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] stride = 2'b00;
    logic [5:0] src_base = 6'd0;
    logic       src_rd_en;
    logic [5:0] src_addr;
    logic [7:0] src_data = 8'd0;
    logic       shift_buffer = 1'b0;
    logic [7:0] out_l1, out_l2, out_l3;
    logic       col_valid, band_done, done, busy;

    int n_assert = 0;
    int n_fail   = 0;

    line_feeder #(.BIT_DEPTH(8), .IMG_W(8), .IMG_H(8), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .stride(stride), .src_base(src_base),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
        .shift_buffer(shift_buffer), .out_l1(out_l1), .out_l2(out_l2), .out_l3(out_l3),
        .col_valid(col_valid), .band_done(band_done), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) src_data <= {2'b00, src_addr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input logic [5:0] base, input int r, input int c);
        logic [5:0] a;
        a = base + 6'(r * 8 + c);
        return {2'b00, a};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_rd_en"}, src_rd_en, 0);
        check({tag, "_addr"}, src_addr, 0);
        check({tag, "_l1"}, out_l1, 0);
        check({tag, "_l2"}, out_l2, 0);
        check({tag, "_l3"}, out_l3, 0);
        check({tag, "_valid"}, col_valid, 0);
        check({tag, "_band_done"}, band_done, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Expects n rows of reads starting at the current negedge.
    task automatic read_rows(input logic [5:0] base, input int r0, input int n);
        logic [5:0] a;
        for (int i = 0; i < n * 8; i++) begin
            a = base + 6'((r0 + i / 8) * 8 + i % 8);
            check($sformatf("rd_en_r%0d_c%0d", r0 + i / 8, i % 8), src_rd_en, 1);
            check($sformatf("addr_r%0d_c%0d", r0 + i / 8, i % 8), src_addr, a);
            check("valid_during_read", col_valid, 0);
            @(negedge clk);
        end
        check("rd_en_after_reads", src_rd_en, 0);
        check("valid_latency", col_valid, 0);
    endtask

    task automatic check_col(input logic [5:0] base, input int rt, input int c);
        check($sformatf("valid_rt%0d_c%0d", rt, c), col_valid, 1);
        check($sformatf("l1_rt%0d_c%0d", rt, c), out_l1, exp_pix(base, rt, c));
        check($sformatf("l2_rt%0d_c%0d", rt, c), out_l2, exp_pix(base, rt + 1, c));
        check($sformatf("l3_rt%0d_c%0d", rt, c), out_l3, exp_pix(base, rt + 2, c));
        check("rd_en_in_stream", src_rd_en, 0);
    endtask

    task automatic run_image(input logic [5:0] base, input logic [1:0] strd, input int nb,
                             input bit hold);
        int s;
        int rt;
        s = (strd == 2'b10) ? 2 : 1;
        start = 1'b1; stride = strd; src_base = base;
        @(negedge clk);
        start = 1'b0; stride = 2'b00; src_base = 6'd0;
        check("busy_after_start", busy, 1);
        if (hold) shift_buffer = 1'b1;
        read_rows(base, 0, 3);
        shift_buffer = 1'b0;
        @(negedge clk);
        for (int b = 0; b < nb; b++) begin
            rt = b * s;
            for (int c = 0; c < 8; c++) begin
                check_col(base, rt, c);
                shift_buffer = 1'b1;
                @(negedge clk);
                shift_buffer = 1'b0;
            end
            check($sformatf("band_done_b%0d", b), band_done, 1);
            check($sformatf("valid_drop_b%0d", b), col_valid, 0);
            if (b < nb - 1) begin
                check($sformatf("no_done_b%0d", b), done, 0);
                read_rows(base, rt + 3, s);
                check("band_done_single", band_done, 0);
                @(negedge clk);
            end else begin
                check("done_pulse", done, 1);
                @(negedge clk);
                check("done_cleared", done, 0);
                check("busy_cleared", busy, 0);
                check("band_done_cleared", band_done, 0);
                check("idle_rd_en", src_rd_en, 0);
            end
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        // Full stride-1 image from base 0 (6 bands)
        run_image(6'd0, 2'b01, 6, 1'b0);
        @(negedge clk);

        // Stride 2 (3 bands)
        run_image(6'd0, 2'b10, 3, 1'b0);
        @(negedge clk);

        // shift_buffer held high while filling must not advance the column
        run_image(6'd0, 2'b00, 6, 1'b1);
        @(negedge clk);

        // Address wrap from base 60
        run_image(6'd60, 2'b01, 6, 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-stream at col 3, then a fresh image
        start = 1'b1; stride = 2'b01; src_base = 6'd0;
        @(negedge clk);
        start = 1'b0;
        read_rows(6'd0, 0, 3);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            shift_buffer = 1'b1;
            @(negedge clk);
            shift_buffer = 1'b0;
        end
        check_col(6'd0, 0, 3);
        #2 rst = 1'b0;
        #1;
        check_quiet("async_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet($sformatf("post_reset_%0d", i));
        end
        run_image(6'd0, 2'b01, 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
